// File: rtl/scl_gen_pkg.sv
// Shared definitions for the SCL generator: phase state encoding and the
// divider clamp used when latching the quarter-period length.
package scl_gen_pkg;

    // Phase sequence of one SCL period plus idle and stretch-timeout parking.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOW_A   = 3'd1,
        ST_LOW_B   = 3'd2,
        ST_HIGH_A  = 3'd3,
        ST_HIGH_B  = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    // A zero divider would give an empty phase; treat it as one cycle.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an open-drain bus line. Resets to 1 so a
// released line is seen as released straight out of reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/scl_gen_param.sv
// SCL generator: divides Mclk into four equal quarter-period phases,
// drives the internal SCL and emits one-cycle phase strobes. Supports
// slave clock stretching in the first half of the high phase with a
// sticky timeout.
module scl_gen_param
    import scl_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int STRETCH_MAX = 65535,
    parameter int TO_WIDTH    = 17
) (
    input  logic                 Mclk,
    input  logic                 reset,
    input  logic                 busy,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 stretch_en,
    input  logic                 scl_in,
    output logic                 iSCL,
    output logic                 scl_fall,
    output logic                 mid_low,
    output logic                 scl_rise,
    output logic                 mid_high,
    output logic                 stretching,
    output logic                 stretch_to
);

    localparam logic [DIV_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE  = DIV_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]  TO_ZERO  = '0;
    localparam logic [TO_WIDTH-1:0]  TO_ONE   = TO_WIDTH'(1);
    localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(STRETCH_MAX - 1);

    state_t                r_state;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_q;
    logic [TO_WIDTH-1:0]   r_to_cnt;
    logic                  r_iscl;
    logic                  r_fall;
    logic                  r_mid_low;
    logic                  r_rise;
    logic                  r_mid_high;
    logic                  r_stretching;
    logic                  r_stretch_to;

    state_t                w_state_next;
    logic [DIV_WIDTH-1:0]  w_cnt_next;
    logic [DIV_WIDTH-1:0]  w_q_next;
    logic [DIV_WIDTH-1:0]  w_q_load;
    logic [TO_WIDTH-1:0]   w_to_next;
    logic                  w_iscl_next;
    logic                  w_fall_next;
    logic                  w_mid_low_next;
    logic                  w_rise_next;
    logic                  w_mid_high_next;
    logic                  w_stretching_next;
    logic                  w_stretch_to_next;
    logic                  w_scl_sync;
    logic                  w_phase_end;
    logic                  w_stretch_cond;

    sync_2ff u_scl_sync (
        .i_clk (Mclk),
        .i_rst (reset),
        .i_d   (scl_in),
        .o_q   (w_scl_sync)
    );

    assign w_q_load       = DIV_WIDTH'(clamp_div(32'(div_val)));
    assign w_phase_end    = (r_cnt == (r_q - CNT_ONE));
    // A slave is holding the line while we have released it.
    assign w_stretch_cond = (r_state == ST_HIGH_A) && stretch_en && !w_scl_sync;

    // Next-state, counter and strobe decode for one quarter-period step.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_q_next          = r_q;
        w_to_next         = r_to_cnt;
        w_fall_next       = 1'b0;
        w_mid_low_next    = 1'b0;
        w_rise_next       = 1'b0;
        w_mid_high_next   = 1'b0;
        w_stretching_next = 1'b0;
        w_stretch_to_next = r_stretch_to;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = CNT_ZERO;
                w_to_next  = TO_ZERO;
                if (busy) begin
                    w_state_next = ST_LOW_A;
                    w_q_next     = w_q_load;
                    w_fall_next  = 1'b1;
                end
            end
            ST_LOW_A: begin
                if (w_phase_end) begin
                    w_state_next   = ST_LOW_B;
                    w_cnt_next     = CNT_ZERO;
                    w_mid_low_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_LOW_B: begin
                if (w_phase_end) begin
                    w_state_next = ST_HIGH_A;
                    w_cnt_next   = CNT_ZERO;
                    w_to_next    = TO_ZERO;
                    w_rise_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_HIGH_A: begin
                if (w_stretch_cond) begin
                    // Phase counter frozen while the line is held low.
                    if (r_to_cnt == TO_LAST) begin
                        w_state_next      = ST_TIMEOUT;
                        w_cnt_next        = CNT_ZERO;
                        w_to_next         = TO_ZERO;
                        w_stretch_to_next = 1'b1;
                    end else begin
                        w_to_next         = r_to_cnt + TO_ONE;
                        w_stretching_next = 1'b1;
                    end
                end else begin
                    w_to_next = TO_ZERO;
                    if (w_phase_end) begin
                        w_state_next    = ST_HIGH_B;
                        w_cnt_next      = CNT_ZERO;
                        w_mid_high_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
            end
            ST_HIGH_B: begin
                if (w_phase_end) begin
                    w_cnt_next = CNT_ZERO;
                    if (busy) begin
                        // Back-to-back periods: no idle cycle in between.
                        w_state_next = ST_LOW_A;
                        w_q_next     = w_q_load;
                        w_fall_next  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            ST_TIMEOUT: begin
                w_cnt_next = CNT_ZERO;
                w_to_next  = TO_ZERO;
                if (!busy) begin
                    w_state_next      = ST_IDLE;
                    w_stretch_to_next = 1'b0;
                end
            end
            default: begin
                w_state_next      = ST_IDLE;
                w_cnt_next        = CNT_ZERO;
                w_to_next         = TO_ZERO;
                w_stretch_to_next = 1'b0;
            end
        endcase
    end

    // SCL is driven low only in the two low phases; released everywhere else.
    assign w_iscl_next = !((w_state_next == ST_LOW_A) || (w_state_next == ST_LOW_B));

    // State and registered outputs.
    always_ff @(posedge Mclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= CNT_ZERO;
            r_q          <= CNT_ONE;
            r_to_cnt     <= TO_ZERO;
            r_iscl       <= 1'b1;
            r_fall       <= 1'b0;
            r_mid_low    <= 1'b0;
            r_rise       <= 1'b0;
            r_mid_high   <= 1'b0;
            r_stretching <= 1'b0;
            r_stretch_to <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_q          <= w_q_next;
            r_to_cnt     <= w_to_next;
            r_iscl       <= w_iscl_next;
            r_fall       <= w_fall_next;
            r_mid_low    <= w_mid_low_next;
            r_rise       <= w_rise_next;
            r_mid_high   <= w_mid_high_next;
            r_stretching <= w_stretching_next;
            r_stretch_to <= w_stretch_to_next;
        end
    end

    assign iSCL       = r_iscl;
    assign scl_fall   = r_fall;
    assign mid_low    = r_mid_low;
    assign scl_rise   = r_rise;
    assign mid_high   = r_mid_high;
    assign stretching = r_stretching;
    assign stretch_to = r_stretch_to;

endmodule

// File: tb/tb_scl_gen_param.sv
// Scoreboard bench for scl_gen_param. Each scenario computes the cycle of
// every expected strobe / flag edge from the period arithmetic and pushes
// it to a time-ordered queue; a monitor compares observed edges per cycle.
module tb_scl_gen_param;

    localparam int TB_SM = 24;

    localparam int EV_FALL = 0;
    localparam int EV_ML   = 1;
    localparam int EV_RISE = 2;
    localparam int EV_MH   = 3;
    localparam int EV_SS   = 4;   // stretching rises
    localparam int EV_SE   = 5;   // stretching falls
    localparam int EV_TOS  = 6;   // stretch_to sets
    localparam int EV_TOC  = 7;   // stretch_to clears

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] div_val;
    logic        stretch_en;
    logic        slave_hold;
    logic        scl_bus;
    logic        iscl;
    logic        scl_fall;
    logic        mid_low;
    logic        scl_rise;
    logic        mid_high;
    logic        stretching;
    logic        stretch_to;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];

    scl_gen_param #(
        .DIV_WIDTH   (16),
        .STRETCH_MAX (TB_SM),
        .TO_WIDTH    (17)
    ) dut (
        .Mclk       (clk),
        .reset      (rst),
        .busy       (busy),
        .div_val    (div_val),
        .stretch_en (stretch_en),
        .scl_in     (scl_bus),
        .iSCL       (iscl),
        .scl_fall   (scl_fall),
        .mid_low    (mid_low),
        .scl_rise   (scl_rise),
        .mid_high   (mid_high),
        .stretching (stretching),
        .stretch_to (stretch_to)
    );

    // Open-drain bus: low if either side pulls it low.
    assign scl_bus = iscl & ~slave_hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic void push_ev(input int c, input int k);
        ev_t e;
        int  i;
        e.cyc  = c;
        e.kind = k;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: per cycle, observed edge set must equal expected edge set,
    // and iSCL must follow the expected fall/rise history.
    initial begin : monitor
        logic [7:0] obs;
        logic [7:0] expm;
        logic       prev_st;
        logic       prev_to;
        logic       exp_level;
        prev_st   = 1'b0;
        prev_to   = 1'b0;
        exp_level = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_st   = 1'b0;
                prev_to   = 1'b0;
                exp_level = 1'b1;
            end else begin
                obs          = '0;
                obs[EV_FALL] = scl_fall;
                obs[EV_ML]   = mid_low;
                obs[EV_RISE] = scl_rise;
                obs[EV_MH]   = mid_high;
                obs[EV_SS]   = stretching & ~prev_st;
                obs[EV_SE]   = ~stretching & prev_st;
                obs[EV_TOS]  = stretch_to & ~prev_to;
                obs[EV_TOC]  = ~stretch_to & prev_to;
                prev_st = stretching;
                prev_to = stretch_to;
                expm = '0;
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    if (sb[0].cyc < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missed_event: kind %0d due @%0d seen none by @%0d",
                                 sb[0].kind, sb[0].cyc, cyc);
                    end else begin
                        expm[sb[0].kind] = 1'b1;
                    end
                    void'(sb.pop_front());
                end
                checks++;
                if (obs != expm) begin
                    errors++;
                    $display("FAIL events @%0d: got %b expected %b", cyc, obs, expm);
                end
                if (expm[EV_FALL]) exp_level = 1'b0;
                if (expm[EV_RISE]) exp_level = 1'b1;
                checks++;
                if (iscl !== exp_level) begin
                    errors++;
                    $display("FAIL iscl_level @%0d: got %b expected %b", cyc, iscl, exp_level);
                end
            end
        end
    end

    // Run nper back-to-back periods starting from IDLE. Each period's Q is
    // the divider present at its falling edge; the divider changes (or busy
    // drops, on the last period) at some cycle inside the running period.
    // With stretching, the high-A phase lasts until Q cycles have been seen
    // with the synchronised line high; a line released before edge e is
    // seen high from cycle e+1.
    task automatic run_periods(input int nper, input bit sten, input int d0, input int d1,
                               input int chg_off, input int drop_off, input int h0);
        int d, q, f, r, u, nf, h, tc, nd;
        stretch_en = sten;
        d          = d0;
        div_val    = 16'(d);
        busy       = 1'b1;
        f          = cyc + 1;
        for (int p = 0; p < nper; p++) begin
            q = (d == 0) ? 1 : d;
            if (!sten)                  h = 0;
            else if (p == 0 && h0 >= 0) h = h0;
            else                        h = (rnd(0, 1) == 0) ? 0 : rnd(1, 20);
            r  = f + 2 * q;
            u  = sten ? r + ((h + 1 > 2) ? h + 1 : 2) : r;
            nf = u + 2 * q;
            $display("period @%0d: div=%0d stretch_en=%0d hold=%0d last=%0d",
                     f, d, sten, h, (p == nper - 1));
            push_ev(f, EV_FALL);
            push_ev(f + q, EV_ML);
            push_ev(r, EV_RISE);
            if (sten) begin
                push_ev(r + 1, EV_SS);
                push_ev(u + 1, EV_SE);
            end
            push_ev(u + q, EV_MH);
            if (h > 0) begin
                wait_until(r - 1);
                slave_hold = 1'b1;
                wait_until(r + h - 1);
                slave_hold = 1'b0;
            end
            if (p < nper - 1) begin
                nd = (p == 0 && d1 >= 0) ? d1 : rnd(0, 5);
                tc = (p == 0 && chg_off >= 0) ? f + chg_off : f + rnd(0, nf - 1 - f);
            end else begin
                nd = d;
                tc = (drop_off >= 0) ? f + drop_off : f + rnd(0, nf - 1 - f);
            end
            if (tc < cyc) tc = cyc;
            wait_until(tc);
            if (p < nper - 1) begin
                div_val = 16'(nd);
                d       = nd;
            end else begin
                busy = 1'b0;
            end
            wait_until(nf - 1);
            f = nf;
        end
        wait_until(f);
    endtask

    // Slave holds SCL low from before the rise: after TB_SM stretching
    // cycles the flag sets and SCL stays released until busy drops.
    task automatic run_timeout(input int d);
        int q, f, r, tc;
        stretch_en = 1'b1;
        div_val    = 16'(d);
        busy       = 1'b1;
        q          = (d == 0) ? 1 : d;
        f          = cyc + 1;
        r          = f + 2 * q;
        $display("timeout @%0d: div=%0d", f, d);
        push_ev(f, EV_FALL);
        push_ev(f + q, EV_ML);
        push_ev(r, EV_RISE);
        push_ev(r + 1, EV_SS);
        push_ev(r + TB_SM, EV_SE);
        push_ev(r + TB_SM, EV_TOS);
        wait_until(r - 1);
        slave_hold = 1'b1;
        tc = r + TB_SM + rnd(0, 5);
        wait_until(tc);
        busy = 1'b0;
        push_ev(tc + 1, EV_TOC);
        wait_until(tc + 1);
        slave_hold = 1'b0;
    endtask

    initial begin : stimulus
        int f;
        int kind;
        rst        = 1'b1;
        busy       = 1'b0;
        div_val    = 16'd0;
        stretch_en = 1'b0;
        slave_hold = 1'b0;

        @(posedge clk);
        #2;
        check("reset_iscl", iscl, 1);
        check("reset_scl_fall", scl_fall, 0);
        check("reset_mid_low", mid_low, 0);
        check("reset_scl_rise", scl_rise, 0);
        check("reset_mid_high", mid_high, 0);
        check("reset_stretching", stretching, 0);
        check("reset_stretch_to", stretch_to, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_periods(2, 1'b0, 2, 2, -1, -1, -1);   // div 2: period 8
        run_periods(2, 1'b0, 0, 0, -1, -1, -1);   // div 0 behaves as 1
        run_periods(2, 1'b0, 1, 3, 1, -1, -1);    // 1 -> 3 during LOW_B
        run_periods(2, 1'b1, 2, 2, -1, -1, 0);    // loopback, high time 6
        run_periods(1, 1'b1, 2, -1, -1, -1, 20);  // slave holds 20 cycles
        run_timeout(2);
        run_periods(1, 1'b0, 2, -1, -1, 0, -1);   // busy dropped in LOW_A

        // Asynchronous reset in the middle of LOW_B, busy kept high.
        busy       = 1'b1;
        div_val    = 16'd4;
        stretch_en = 1'b0;
        f          = cyc + 1;
        push_ev(f, EV_FALL);
        push_ev(f + 4, EV_ML);
        wait_until(f + 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_iscl", iscl, 1);
        check("async_rst_scl_fall", scl_fall, 0);
        check("async_rst_mid_low", mid_low, 0);
        check("async_rst_scl_rise", scl_rise, 0);
        check("async_rst_mid_high", mid_high, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        run_periods(1, 1'b0, 4, -1, -1, -1, -1);

        for (int it = 0; it < 30; it++) begin
            kind = rnd(0, 9);
            if (kind < 5)      run_periods(rnd(1, 3), 1'b0, rnd(0, 5), -1, -1, -1, -1);
            else if (kind < 9) run_periods(rnd(1, 3), 1'b1, rnd(0, 5), -1, -1, -1, -1);
            else               run_timeout(rnd(0, 4));
            repeat (rnd(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", sb.size(), 0);
        check("final_iscl", iscl, 1);
        check("final_stretch_to", stretch_to, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
